// File: rtl/i2c_target_rx.sv
// i2c_target_rx: I2C write-only target that ACKs its address and strobes out each received data byte.
// Build option: define I2C_GENERAL_CALL_EN to also accept the general-call address byte 8'h00.
module i2c_target_rx #(
   parameter logic [6:0] ADDR        = 7'h2A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] data_o,
   output logic       data_valid_o,
   output logic       busy_o
);
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] scl_q, sda_q;
   logic scl_s, sda_s, scl_h, sda_h;
   logic scl_rise, scl_fall, start, stop, addr_ok;
   logic [2:0] cnt, cnt_n;
   logic [6:0] sh, sh_n;
   logic [7:0] byte_w, data_n;
   logic oe_n, busy_n, valid_n;
   assign scl_s    = scl_q[SYNC_STAGES-1];
   assign sda_s    = sda_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_h;
   assign scl_fall = ~scl_s & scl_h;
   assign start    = scl_s & scl_h & sda_h & ~sda_s;
   assign stop     = scl_s & scl_h & ~sda_h & sda_s;
   assign byte_w   = {sh, sda_s};
`ifdef I2C_GENERAL_CALL_EN
   assign addr_ok  = (byte_w[7:1] == ADDR && !byte_w[0]) || byte_w == 8'h00;
`else
   assign addr_ok  = byte_w[7:1] == ADDR && !byte_w[0];
`endif
   // Synchronizers idle high so reset release on a quiet bus creates no edges.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         scl_q <= '1;
         sda_q <= '1;
         scl_h <= 1'b1;
         sda_h <= 1'b1;
      end else begin
         scl_q <= {scl_q[SYNC_STAGES-2:0], scl_i};
         sda_q <= {sda_q[SYNC_STAGES-2:0], sda_i};
         scl_h <= scl_s;
         sda_h <= sda_s;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= 3'd0;
         sh           <= 7'd0;
         sda_oe       <= 1'b0;
         busy_o       <= 1'b0;
         data_o       <= 8'h00;
         data_valid_o <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         sh           <= sh_n;
         sda_oe       <= oe_n;
         busy_o       <= busy_n;
         data_o       <= data_n;
         data_valid_o <= valid_n;
      end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sh_n    = sh;
      oe_n    = sda_oe;
      busy_n  = busy_o;
      data_n  = data_o;
      valid_n = 1'b0;
      if (start || stop) begin
         state_n = start ? S_ADDR : S_IDLE;
         cnt_n   = 3'd0;
         sh_n    = 7'd0;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else begin
         case (state)
            S_ADDR, S_DATA:
               if (scl_rise) begin
                  sh_n  = byte_w[6:0];
                  cnt_n = cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     if (state == S_ADDR)
                        state_n = addr_ok ? S_ADDR_ACK : S_IGNORE;
                     else begin
                        data_n  = byte_w;
                        valid_n = 1'b1;
                        state_n = S_DATA_ACK;
                     end
                  end
               end
            // First falling edge drives ACK, second releases it and opens the data phase.
            S_ADDR_ACK, S_DATA_ACK:
               if (scl_fall) begin
                  oe_n = !sda_oe;
                  if (sda_oe) begin
                     busy_n  = 1'b1;
                     state_n = S_DATA;
                  end
               end
            default: oe_n = 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: directed and randomized I2C write transfers checked against a transaction-level model.
`timescale 1ns/1ps
module tb_i2c_target_rx;
   localparam int Q = 5;
`ifdef I2C_GENERAL_CALL_EN
   localparam bit GC = 1'b1;
`else
   localparam bit GC = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scl = 1'b1;
   logic m_sda = 1'b1;
   logic sda_line, sda_oe, data_valid_o, busy_o;
   logic [7:0] data_o;
   logic [7:0] got_q[$], exp_q[$], tx_q[$];
   int checks = 0, failures = 0;
   int width_err = 0, hold_err = 0, oe_err = 0;
   logic prev_v = 1'b0, prev_oe = 1'b0;
   logic [7:0] last_d = 8'h00;
   assign sda_line = m_sda & ~sda_oe;
   always #5 clk = ~clk;
   i2c_target_rx dut (
      .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line),
      .sda_oe(sda_oe), .data_o(data_o), .data_valid_o(data_valid_o), .busy_o(busy_o)
   );
   // Strobe capture plus pulse-width, hold and ACK-edge rules.
   always @(negedge clk) begin
      if (rst_n) begin
         if (data_valid_o) got_q.push_back(data_o);
         if (data_valid_o && prev_v) width_err++;
         if (!data_valid_o && data_o !== last_d) hold_err++;
         if (sda_oe !== prev_oe && scl) oe_err++;
      end
      prev_v  = data_valid_o;
      last_d  = data_o;
      prev_oe = sda_oe;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic wc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic i2c_start();
      m_sda = 1'b1; wc(Q);
      scl = 1'b1; wc(Q);
      m_sda = 1'b0; wc(Q);
      scl = 1'b0; wc(Q);
   endtask
   task automatic i2c_stop();
      m_sda = 1'b0; wc(Q);
      scl = 1'b1; wc(Q);
      m_sda = 1'b1; wc(2 * Q);
   endtask
   task automatic send_bit(input logic b);
      m_sda = b; wc(Q);
      scl = 1'b1; wc(2 * Q);
      scl = 1'b0; wc(Q);
   endtask
   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      m_sda = 1'b1; wc(Q);
      scl = 1'b1; wc(Q);
      ack = sda_oe;
      wc(Q);
      scl = 1'b0; wc(Q);
   endtask
   function automatic bit match(input logic [7:0] a);
      return (a[7:1] == 7'h2A && a[0] == 1'b0) || (GC && a == 8'h00);
   endfunction
   task automatic compare_q(input string tag);
      chk({tag, ":n_strobes"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk({tag, ":strobe_data"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask
   task automatic xfer(input string tag, input logic [7:0] a);
      logic ack;
      bit m;
      m = match(a);
      i2c_start();
      send_byte(a, ack);
      chk({tag, ":addr_ack"}, ack, m);
      chk({tag, ":busy"}, busy_o, m);
      foreach (tx_q[i]) begin
         send_byte(tx_q[i], ack);
         chk({tag, ":data_ack"}, ack, m);
         if (m) exp_q.push_back(tx_q[i]);
      end
      i2c_stop();
      wc(10);
      chk({tag, ":busy_after_stop"}, busy_o, 0);
      compare_q(tag);
   endtask
   initial begin
      logic ack;
      logic [7:0] a;
      wc(3);
      chk("reset:sda_oe", sda_oe, 0);
      chk("reset:data", data_o, 8'h00);
      chk("reset:valid", data_valid_o, 0);
      chk("reset:busy", busy_o, 0);
      rst_n = 1'b1;
      wc(10);
      tx_q = '{8'hFF};
      xfer("mismatch", 8'h22);
      chk("mismatch:data_hold", data_o, 8'h00);
      tx_q = '{8'h5B};
      xfer("basic", 8'h54);
      chk("basic:data", data_o, 8'h5B);
      tx_q = '{8'h11};
      xfer("read", 8'h55);
      tx_q = '{8'h3F, 8'h06, 8'h4F};
      xfer("multi", 8'h54);
      i2c_start();
      send_byte(8'h54, ack);
      send_byte(8'h3F, ack);
      chk("rstart:first_ack", ack, 1);
      exp_q.push_back(8'h3F);
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      tx_q = '{8'h66};
      xfer("rstart", 8'h54);
      i2c_start();
      send_byte(8'h54, ack);
      send_byte(8'h3C, ack);
      exp_q.push_back(8'h3C);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      chk("midrst:busy_before", busy_o, 1);
      chk("midrst:data_before", data_o, 8'h3C);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst:sda_oe", sda_oe, 0);
      chk("midrst:busy", busy_o, 0);
      chk("midrst:data", data_o, 8'h00);
      wc(3);
      rst_n = 1'b1;
      i2c_stop();
      wc(10);
      compare_q("midrst");
      tx_q = '{8'hA5};
      xfer("after_rst", 8'h54);
      chk("after_rst:data", data_o, 8'hA5);
      tx_q = '{8'h12};
      xfer("gcall", 8'h00);
      for (int t = 0; t < 6; t++) begin
         case ($urandom_range(0, 3))
            0: a = 8'h54;
            1: a = 8'h55;
            2: a = 8'h00;
            default: a = 8'($urandom);
         endcase
         tx_q.delete();
         for (int i = $urandom_range(1, 3); i > 0; i--) tx_q.push_back(8'($urandom));
         xfer("random", a);
      end
      chk("strobe_width", width_err, 0);
      chk("data_hold", hold_err, 0);
      chk("oe_edge_scl_low", oe_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
